firmware_pio_write_arbiter: RTL and testbench

//  Shares the firmware PIO command register (Avalon-MM slave s1, addr 0, 32b) between
//  NUM_REQ hardware requesters (trig core, host bridge, ...). Round-robin arbitration,

---
 rtl/firmware_pio_pkg.sv | 17 +
 rtl/firmware_pio_write_arbiter_rr_arbiter.sv | 33 +++
 rtl/firmware_pio_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_firmware_pio_write_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/firmware_pio_pkg.sv
// Shared constants for the firmware PIO write arbiter: FSM state encoding,
// PIO command register address/width, and a modular pointer-advance helper.
package firmware_pio_pkg;

    localparam int         PIO_DATA_W   = 32;
    localparam logic [1:0] PIO_CMD_ADDR = 2'd0;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WRITE  = 2'd1;
    localparam logic [1:0] ST_VERIFY = 2'd2;
    localparam logic [1:0] ST_ACK    = 2'd3;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 32'sd1 >= n) ? 32'sd0 : idx + 32'sd1;
    endfunction

endpackage

// File: rtl/firmware_pio_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i
// (wrapping modulo NUM_REQ) wins.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    int               cand_s;
    logic [IDX_W-1:0] cand_idx_s;

    // Walk offsets from farthest to nearest so the nearest hit is the last one written.
    always_comb begin
        valid_o    = 1'b0;
        idx_o      = {IDX_W{1'b0}};
        cand_s     = 32'sd0;
        cand_idx_s = {IDX_W{1'b0}};
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand_s     = int'(ptr_i) + k;
            cand_s     = (cand_s >= NUM_REQ) ? cand_s - NUM_REQ : cand_s;
            cand_idx_s = IDX_W'(cand_s);
            idx_o      = req_i[cand_idx_s] ? cand_idx_s : idx_o;
            valid_o    = valid_o | req_i[cand_idx_s];
        end
        grant_o = valid_o ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << idx_o) : {NUM_REQ{1'b0}};
    end

endmodule

// File: rtl/firmware_pio_write_arbiter.sv
// Shares the firmware PIO command register between NUM_REQ requesters:
// round-robin grant, one-cycle write, read-back verify, ack with error flag, idle gap.
module firmware_pio_write_arbiter
    import firmware_pio_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int MIN_GAP = 4,
    parameter int ERR_W   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*32-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]      ack,
    output logic                    ack_err,
    output logic                    busy,
    output logic [ERR_W-1:0]        err_count,
    output logic [1:0]              avm_address,
    output logic                    avm_chipselect,
    output logic                    avm_write_n,
    output logic [31:0]             avm_writedata,
    input  logic [31:0]             avm_readdata
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]            state_q, state_d;
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]      gidx_q, gidx_d;
    logic [7:0]            gap_q, gap_d;
    logic [PIO_DATA_W-1:0] data_q, data_d;
    logic [NUM_REQ-1:0]    ack_q, ack_d;
    logic                  ack_err_q, ack_err_d;
    logic                  busy_q, busy_d;
    logic                  cs_q, cs_d;
    logic                  wn_q, wn_d;
    logic [ERR_W-1:0]      err_q, err_d;

    logic [NUM_REQ-1:0]    arb_grant_s;
    logic [IDX_W-1:0]      arb_idx_s;
    logic                  arb_valid_s;
    logic [PIO_DATA_W-1:0] sel_data_s;
    logic                  mismatch_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant_s),
        .idx_o   (arb_idx_s),
        .valid_o (arb_valid_s)
    );

    // Grant is one-hot, so an AND-OR mux selects the winner's data word.
    always_comb begin
        sel_data_s = {PIO_DATA_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            sel_data_s = sel_data_s
                       | (req_wdata[k*PIO_DATA_W +: PIO_DATA_W] & {PIO_DATA_W{arb_grant_s[k]}});
        end
    end

    assign mismatch_s = (avm_readdata != data_q);

    // Next-state logic; all Avalon and handshake outputs are computed one cycle ahead.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        gidx_d    = gidx_q;
        gap_d     = gap_q;
        data_d    = data_q;
        ack_d     = {NUM_REQ{1'b0}};
        ack_err_d = 1'b0;
        busy_d    = busy_q;
        cs_d      = 1'b0;
        wn_d      = 1'b1;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                if (gap_q != 8'd0) begin
                    gap_d = gap_q - 8'd1;
                end else if (arb_valid_s) begin
                    gidx_d  = arb_idx_s;
                    data_d  = sel_data_s;
                    state_d = ST_WRITE;
                    busy_d  = 1'b1;
                    cs_d    = 1'b1;
                    wn_d    = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_d = ST_VERIFY;
                cs_d    = 1'b1;
            end
            ST_VERIFY: begin
                // Readdata reflects the register updated at the end of WRITE.
                state_d   = ST_ACK;
                ack_d     = {{(NUM_REQ-1){1'b0}}, 1'b1} << gidx_q;
                ack_err_d = mismatch_s;
                if (mismatch_s && (err_q != {ERR_W{1'b1}})) begin
                    err_d = err_q + ERR_W'(1'b1);
                end else begin
                    err_d = err_q;
                end
            end
            ST_ACK: begin
                state_d  = ST_IDLE;
                busy_d   = 1'b0;
                rr_ptr_d = IDX_W'(wrap_inc(int'(gidx_q), NUM_REQ));
                gap_d    = 8'(MIN_GAP);
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= {IDX_W{1'b0}};
            gidx_q    <= {IDX_W{1'b0}};
            gap_q     <= 8'd0;
            data_q    <= {PIO_DATA_W{1'b0}};
            ack_q     <= {NUM_REQ{1'b0}};
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            cs_q      <= 1'b0;
            wn_q      <= 1'b1;
            err_q     <= {ERR_W{1'b0}};
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            gidx_q    <= gidx_d;
            gap_q     <= gap_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            cs_q      <= cs_d;
            wn_q      <= wn_d;
            err_q     <= err_d;
        end
    end

    assign ack            = ack_q;
    assign ack_err        = ack_err_q;
    assign busy           = busy_q;
    assign err_count      = err_q;
    assign avm_address    = PIO_CMD_ADDR;
    assign avm_chipselect = cs_q;
    assign avm_write_n    = wn_q;
    assign avm_writedata  = data_q;

endmodule

// File: tb/tb_firmware_pio_write_arbiter.sv
// Directed bench: two arbiter instances (MIN_GAP=4 and MIN_GAP=0), each with a
// behavioural PIO slave; the first slave's readdata can be corrupted by a fault hook.
module tb_firmware_pio_write_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        fault_en;

    logic [1:0]  req, req0;
    logic [63:0] wdata, wdata0;

    logic [1:0]  ack, ack0;
    logic        ack_err, ack_err0, busy, busy0;
    logic [7:0]  err_count, err_count0;
    logic [1:0]  addr, addr0;
    logic        cs, cs0, wn, wn0;
    logic [31:0] wd, wd0, rdata, rdata0;
    logic [31:0] pio_q, pio0_q;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    firmware_pio_write_arbiter #(.NUM_REQ(2), .MIN_GAP(4), .ERR_W(8)) dut (
        .clk(clk), .reset(reset), .req(req), .req_wdata(wdata),
        .ack(ack), .ack_err(ack_err), .busy(busy), .err_count(err_count),
        .avm_address(addr), .avm_chipselect(cs), .avm_write_n(wn),
        .avm_writedata(wd), .avm_readdata(rdata)
    );

    firmware_pio_write_arbiter #(.NUM_REQ(2), .MIN_GAP(0), .ERR_W(8)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .req_wdata(wdata0),
        .ack(ack0), .ack_err(ack_err0), .busy(busy0), .err_count(err_count0),
        .avm_address(addr0), .avm_chipselect(cs0), .avm_write_n(wn0),
        .avm_writedata(wd0), .avm_readdata(rdata0)
    );

    // Behavioural PIO slaves: register written on a write strobe, readdata combinational.
    always @(posedge clk) begin
        if (cs && !wn && addr == 2'd0) pio_q <= wd;
        if (cs0 && !wn0 && addr0 == 2'd0) pio0_q <= wd0;
    end
    assign rdata  = pio_q ^ {31'd0, fault_en};
    assign rdata0 = pio0_q;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 2'b00;
        req0  = 2'b00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Raise one request, wait (bounded) for its ack, drop the request in the ack cycle.
    task automatic do_txn(input int idx, input logic [31:0] d,
                          output logic [1:0] a, output logic ae, output int lat);
        req[idx] = 1'b1;
        wdata[idx*32 +: 32] = d;
        a   = 2'b00;
        ae  = 1'b0;
        lat = 0;
        for (int n = 0; n < 40; n++) begin
            tick();
            lat++;
            if (ack !== 2'b00) begin
                a  = ack;
                ae = ack_err;
                break;
            end
        end
        req[idx] = 1'b0;
        if (a == 2'b00) lat = -1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ack !== 2'b00 || ack_err !== 1'b0) begin failures++;
            $display("FAIL reset_ack got ack=%b err=%b exp ack=00 err=0", ack, ack_err); end
        checks++; if (busy !== 1'b0 || err_count !== 8'd0) begin failures++;
            $display("FAIL reset_busy_err got busy=%b cnt=%0d exp 0/0", busy, err_count); end
        checks++; if (cs !== 1'b0 || wn !== 1'b1 || addr !== 2'd0 || wd !== 32'd0) begin failures++;
            $display("FAIL reset_avm got cs=%b wn=%b addr=%0d wd=%h exp 0/1/0/0", cs, wn, addr, wd); end
    endtask

    task automatic test_single();
        do_reset();
        req[0] = 1'b1;
        wdata[31:0] = 32'hDEAD_BEEF;
        tick();
        checks++; if (cs !== 1'b1 || wn !== 1'b0 || wd !== 32'hDEAD_BEEF) begin failures++;
            $display("FAIL single_write got cs=%b wn=%b wd=%h exp 1/0/deadbeef", cs, wn, wd); end
        tick();
        checks++; if (cs !== 1'b1 || wn !== 1'b1 || ack !== 2'b00) begin failures++;
            $display("FAIL single_verify got cs=%b wn=%b ack=%b exp 1/1/00", cs, wn, ack); end
        tick();
        req = 2'b00;
        checks++; if (ack !== 2'b01 || ack_err !== 1'b0) begin failures++;
            $display("FAIL single_ack got ack=%b err=%b exp 01/0", ack, ack_err); end
        checks++; if (pio_q !== 32'hDEAD_BEEF) begin failures++;
            $display("FAIL single_out_port got %h exp deadbeef", pio_q); end
    endtask

    task automatic test_round_robin();
        int          wcyc[$];
        int          acyc[$];
        logic [1:0]  av[$];
        logic        errs;
        do_reset();
        errs  = 1'b0;
        wdata = {32'h0000_0022, 32'h0000_0011};
        req   = 2'b11;
        for (int n = 0; n < 60 && av.size() < 2; n++) begin
            tick();
            if (cs && !wn) wcyc.push_back(n + 1);
            if (ack !== 2'b00) begin
                av.push_back(ack);
                acyc.push_back(n + 1);
                errs = errs | ack_err;
                req  = req & ~ack;
            end
        end
        req = 2'b00;
        checks++; if (av.size() != 2 || wcyc.size() != 2) begin failures++;
            $display("FAIL rr_count got acks=%0d writes=%0d exp 2/2", av.size(), wcyc.size()); end
        else begin
            checks++; if (av[0] !== 2'b01 || av[1] !== 2'b10) begin failures++;
                $display("FAIL rr_order got %b,%b exp 01,10", av[0], av[1]); end
            // Ack at t, four gap cycles, grant at t+5, second WRITE at t+6.
            checks++; if (wcyc[0] != 1 || wcyc[1] - acyc[0] != 6) begin failures++;
                $display("FAIL rr_gap got w0=%0d w1-ack0=%0d exp 1/6", wcyc[0], wcyc[1] - acyc[0]); end
        end
        checks++; if (pio_q !== 32'h0000_0022 || errs !== 1'b0) begin failures++;
            $display("FAIL rr_out_port got %h err=%b exp 00000022/0", pio_q, errs); end
    endtask

    task automatic test_err_saturation();
        logic [1:0] a;
        logic       ae;
        int         lat;
        int         bad;
        do_reset();
        fault_en = 1'b1;
        do_txn(0, 32'hA5A5_0001, a, ae, lat);
        checks++; if (a !== 2'b01 || ae !== 1'b1 || err_count !== 8'd1) begin failures++;
            $display("FAIL err_first got ack=%b err=%b cnt=%0d exp 01/1/1", a, ae, err_count); end
        bad = 0;
        for (int i = 1; i < 259; i++) begin
            do_txn(0, 32'hA5A5_0001 + i, a, ae, lat);
            if (a !== 2'b01 || ae !== 1'b1) bad++;
        end
        checks++; if (bad != 0 || err_count !== 8'hFF) begin failures++;
            $display("FAIL err_saturate got bad=%0d cnt=%0d exp 0/255", bad, err_count); end
        fault_en = 1'b0;
        do_txn(0, 32'h0F0F_0F0F, a, ae, lat);
        checks++; if (a !== 2'b01 || ae !== 1'b0 || err_count !== 8'hFF) begin failures++;
            $display("FAIL err_clean got ack=%b err=%b cnt=%0d exp 01/0/255", a, ae, err_count); end
    endtask

    task automatic test_reset_mid();
        logic [1:0] a;
        logic       ae;
        int         lat;
        int         ghost;
        do_reset();
        do_txn(0, 32'h1234_5678, a, ae, lat);
        repeat (6) tick();
        req[0] = 1'b1;
        wdata[31:0] = 32'hCAFE_F00D;
        tick();
        tick();
        checks++; if (cs !== 1'b1 || wn !== 1'b1) begin failures++;
            $display("FAIL rst_mid_in_verify got cs=%b wn=%b exp 1/1", cs, wn); end
        reset = 1'b1;
        req   = 2'b00;
        tick();
        checks++; if (cs !== 1'b0 || wn !== 1'b1 || busy !== 1'b0 || ack !== 2'b00 || wd !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs got cs=%b wn=%b busy=%b ack=%b wd=%h exp 0/1/0/00/0",
                     cs, wn, busy, ack, wd); end
        checks++; if (dut.rr_ptr_q !== 1'b0) begin failures++;
            $display("FAIL rst_mid_rr_ptr got %b exp 0", dut.rr_ptr_q); end
        checks++; if (pio_q !== 32'hCAFE_F00D) begin failures++;
            $display("FAIL rst_mid_write_kept got %h exp cafef00d", pio_q); end
        reset = 1'b0;
        ghost = 0;
        repeat (6) begin
            tick();
            if (ack !== 2'b00) ghost++;
        end
        checks++; if (ghost != 0) begin failures++;
            $display("FAIL rst_mid_no_ack got %0d acks exp 0", ghost); end
        do_txn(1, 32'h0BAD_CAFE, a, ae, lat);
        checks++; if (lat != 3 || a !== 2'b10 || ae !== 1'b0 || pio_q !== 32'h0BAD_CAFE) begin failures++;
            $display("FAIL rst_mid_fresh got lat=%0d ack=%b err=%b out=%h exp 3/10/0/0badcafe",
                     lat, a, ae, pio_q); end
    endtask

    task automatic test_drop_in_write();
        int         ack_at;
        logic [1:0] a;
        int         extra_wr;
        do_reset();
        req[1] = 1'b1;
        wdata[63:32] = 32'h5555_AAAA;
        tick();
        checks++; if (cs !== 1'b1 || wn !== 1'b0) begin failures++;
            $display("FAIL drop_write_phase got cs=%b wn=%b exp 1/0", cs, wn); end
        req = 2'b00;
        ack_at   = -1;
        a        = 2'b00;
        extra_wr = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (ack !== 2'b00 && ack_at < 0) begin
                ack_at = n;
                a      = ack;
            end
            if (cs && !wn) extra_wr++;
        end
        checks++; if (ack_at != 1 || a !== 2'b10) begin failures++;
            $display("FAIL drop_ack got at=%0d ack=%b exp 1/10", ack_at, a); end
        checks++; if (extra_wr != 0 || pio_q !== 32'h5555_AAAA) begin failures++;
            $display("FAIL drop_no_rewrite got writes=%0d out=%h exp 0/5555aaaa", extra_wr, pio_q); end
    endtask

    task automatic test_back_to_back();
        int         wcyc[$];
        logic [1:0] av[$];
        int         viol;
        int         alt_bad;
        int         gap_bad;
        int         errs;
        do_reset();
        viol   = 0;
        errs   = 0;
        wdata0 = {32'hBBBB_0001, 32'hAAAA_0000};
        req0   = 2'b11;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (cs0 && !wn0) wcyc.push_back(n + 1);
            if (ack0 !== 2'b00) begin
                av.push_back(ack0);
                if (ack_err0 !== 1'b0) errs++;
            end
            if (cs0 && (!busy0 || ack0 !== 2'b00)) viol++;
        end
        req0 = 2'b00;
        alt_bad = 0;
        for (int i = 0; i < av.size(); i++) begin
            if (av[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) alt_bad++;
        end
        gap_bad = 0;
        for (int i = 1; i < wcyc.size(); i++) begin
            if (wcyc[i] - wcyc[i-1] != 4) gap_bad++;
        end
        checks++; if (av.size() != 12 || wcyc.size() != 13) begin failures++;
            $display("FAIL b2b_count got acks=%0d writes=%0d exp 12/13", av.size(), wcyc.size()); end
        checks++; if (alt_bad != 0) begin failures++;
            $display("FAIL b2b_alternation got %0d out-of-order acks exp 0", alt_bad); end
        checks++; if (gap_bad != 0) begin failures++;
            $display("FAIL b2b_spacing got %0d bad write gaps exp 0", gap_bad); end
        checks++; if (viol != 0 || errs != 0 || err_count0 !== 8'd0) begin failures++;
            $display("FAIL b2b_cs_idle_ack got viol=%0d errs=%0d cnt=%0d exp 0/0/0",
                     viol, errs, err_count0); end
    endtask

    initial begin
        reset    = 1'b1;
        fault_en = 1'b0;
        req      = 2'b00;
        req0     = 2'b00;
        wdata    = 64'd0;
        wdata0   = 64'd0;
        test_reset();
        test_single();
        test_round_robin();
        test_err_saturation();
        test_reset_mid();
        test_drop_in_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
